// File: rtl/data_mem_responder.sv
// Word-wide data-memory responder: one request in flight, RAM access after WAIT_CYCLES wait states.
// Response appears T+1+WAIT_CYCLES after acceptance and is held until rsp_ready; no new request until then.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic        accept;
    logic        commit;
    logic        rsp_clr;
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_be;
    logic [31:0] c_off;
    logic [AW-1:0] c_idx;
    logic        c_err;
    logic        mem_wr;

    assign req_ready = (state_q == S_IDLE) & ~reset;
    assign accept    = req_valid & req_ready;

    // With zero wait states the commit happens on the acceptance edge, so the
    // live request fields are used in IDLE and the latched copy otherwise.
    always_comb begin
        if (state_q == S_IDLE) begin
            c_we    = req_we;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_be    = req_be;
        end else begin
            c_we    = we_q;
            c_addr  = addr_q;
            c_wdata = wdata_q;
            c_be    = be_q;
        end
        c_off = c_addr - BASE_ADDR;
        c_idx = c_off[AW+1:2];
        c_err = (c_addr[1:0] != 2'b00) | (c_off >= SPAN);
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        commit      = 1'b0;
        rsp_clr     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    if (WAIT_CYCLES == 0) begin
                        commit  = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        wait_cnt_d = WAIT_LOAD;
                        state_d    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_clr     = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (commit) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = c_err;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            be_q        <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Registered read port; stores and errors return zero data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_rdata_q <= 32'd0;
        end else if (commit) begin
            rsp_rdata_q <= (c_we | c_err) ? 32'd0 : mem_q[c_idx];
        end else if (rsp_clr) begin
            rsp_rdata_q <= 32'd0;
        end
    end

    // A commit that lands on a reset edge must not disturb storage.
    assign mem_wr = commit & c_we & ~c_err & ~reset;

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (c_be[b]) begin
                    mem_q[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: three instances cover WAIT_CYCLES 1, 0 and 3.
module tb_data_mem_responder;

    logic        clk;
    logic        rst       [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] mdl [int];

    function automatic int wait_of(input int i);
        case (i)
            0: return 1;
            1: return 0;
            default: return 3;
        endcase
    endfunction

    function automatic logic [31:0] base_of(input int i);
        return (i == 2) ? 32'h0000_1000 : 32'h0000_0000;
    endfunction

    function automatic int depth_of(input int i);
        return (i == 2) ? 16 : 1024;
    endfunction

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1), .BASE_ADDR(32'h0000_0000)) u_w1 (
        .clk(clk), .reset(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_0000)) u_w0 (
        .clk(clk), .reset(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    data_mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(3), .BASE_ADDR(32'h0000_1000)) u_w3 (
        .clk(clk), .reset(rst[2]),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model prediction is pushed at acceptance and popped when the response shows up.
    task automatic txn(input int i, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be, input int hold,
                       output logic [31:0] rd);
        exp_t        e;
        int          n;
        int          key;
        logic [31:0] off;
        logic [31:0] old;
        logic [31:0] held;

        @(negedge clk);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = wd;
        req_be[i]    = be;
        rsp_ready[i] = (hold == 0);
        n = 0;
        while (!req_ready[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[i]) begin
            chk("accept_timeout", 32'(req_ready[i]), 32'd1);
            req_valid[i] = 1'b0;
            rd = 32'd0;
            return;
        end

        off   = addr - base_of(i);
        e.err = (addr[1:0] != 2'b00) || (off >= 32'(depth_of(i) * 4));
        key   = i * (1 << 20) + int'((off >> 2) & 32'(depth_of(i) - 1));
        if (e.err) begin
            e.rdata = 32'd0;
        end else if (we) begin
            old = mdl.exists(key) ? mdl[key] : 32'd0;
            for (int b = 0; b < 4; b++) begin
                if (be[b]) old[8*b +: 8] = wd[8*b +: 8];
            end
            mdl[key] = old;
            e.rdata  = 32'd0;
        end else begin
            e.rdata = mdl.exists(key) ? mdl[key] : 32'hxxxx_xxxx;
        end
        exp_q.push_back(e);

        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            req_valid[i] = 1'b0;
        end while (!rsp_valid[i] && n < 50);
        chk($sformatf("latency_w%0d", wait_of(i)), 32'(n), 32'(1 + wait_of(i)));

        e = exp_q.pop_front();
        chk($sformatf("rdata_%h", addr), rsp_rdata[i], e.rdata);
        chk($sformatf("err_%h", addr), 32'(rsp_err[i]), 32'(e.err));
        rd   = rsp_rdata[i];
        held = rsp_rdata[i];

        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                chk("bp_valid", 32'(rsp_valid[i]), 32'd1);
                chk("bp_rdata", rsp_rdata[i], held);
                chk("bp_req_ready", 32'(req_ready[i]), 32'd0);
            end
            rsp_ready[i] = 1'b1;
        end

        @(negedge clk);
        chk("post_valid", 32'(rsp_valid[i]), 32'd0);
        chk("post_rdata", rsp_rdata[i], 32'd0);
        chk("post_err", 32'(rsp_err[i]), 32'd0);
        chk("post_req_ready", 32'(req_ready[i]), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        int          n;

        for (int i = 0; i < 3; i++) begin
            rst[i]       = 1'b1;
            req_valid[i] = 1'b1;
            req_we[i]    = 1'b1;
            req_addr[i]  = base_of(i);
            req_wdata[i] = 32'h5555_AAAA;
            req_be[i]    = 4'hF;
            rsp_ready[i] = 1'b1;
        end

        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk("rst_req_ready", 32'(req_ready[i]), 32'd0);
                chk("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
                chk("rst_rsp_rdata", rsp_rdata[i], 32'd0);
            end
        end
        for (int i = 0; i < 3; i++) begin
            rst[i]       = 1'b0;
            req_valid[i] = 1'b0;
        end
        #1;
        for (int i = 0; i < 3; i++) chk("rel_req_ready", 32'(req_ready[i]), 32'd1);

        // WAIT_CYCLES = 1: store/load, byte lanes, errors, backpressure
        txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
        chk("load_beef", rd, 32'hDEAD_BEEF);
        txn(0, 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 0, rd);
        txn(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, rd);
        chk("byte_lanes", rd, 32'hDE22_BE44);
        txn(0, 1'b1, 32'h0, 32'hA5A5_0001, 4'hF, 0, rd);
        txn(0, 1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 0, rd);
        txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, rd);
        chk("no_alias", rd, 32'hA5A5_0001);
        txn(0, 1'b0, 32'h12, 32'h0, 4'h0, 0, rd);
        chk("misaligned_rdata", rd, 32'd0);
        txn(0, 1'b1, 32'h10, 32'h9999_9999, 4'b0000, 0, rd);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, rd);
        chk("be_zero_noop", rd, 32'hDE22_BE44);

        // WAIT_CYCLES = 0
        txn(1, 1'b1, 32'h20, 32'h1234_5678, 4'hF, 0, rd);
        txn(1, 1'b0, 32'h20, 32'h0, 4'h0, 2, rd);
        chk("w0_load", rd, 32'h1234_5678);

        // WAIT_CYCLES = 3 with non-zero base
        txn(2, 1'b1, 32'h1004, 32'h0BAD_0001, 4'hF, 0, rd);
        txn(2, 1'b0, 32'h1004, 32'h0, 4'h0, 0, rd);
        chk("w3_load", rd, 32'h0BAD_0001);
        txn(2, 1'b0, 32'h0FFC, 32'h0, 4'h0, 0, rd);
        txn(2, 1'b0, 32'h1040, 32'h0, 4'h0, 0, rd);

        // Abort a store by reset two edges after acceptance
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_addr[2]  = 32'h1004;
        req_wdata[2] = 32'hCAFE_F00D;
        req_be[2]    = 4'hF;
        rsp_ready[2] = 1'b1;
        n = 0;
        while (!req_ready[2] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("abort_accept", 32'(req_ready[2]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        rst[2] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_req_ready", 32'(req_ready[2]), 32'd0);
            chk("abort_rsp_valid", 32'(rsp_valid[2]), 32'd0);
        end
        rst[2]       = 1'b0;
        req_valid[2] = 1'b0;
        #1;
        chk("abort_rel_ready", 32'(req_ready[2]), 32'd1);
        txn(2, 1'b0, 32'h1004, 32'h0, 4'h0, 0, rd);
        chk("abort_no_write", rd, 32'h0BAD_0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
